spike_fifo_sched: RTL
=====================

# spike_fifo_sched

Write-side arbiter and per-tick read scheduler for the axon-decoder spike FIFO (`synchronous_fifo`). It merges up to NUM_REQ spike sources into the FIFO's single write port with round-robin fairness. On each global `tick` it drains exactly the packets present at that tick into the axon decoder, then pulses `tick_done`. It sits between the router/input ports and the FIFO, and drives the FIFO's `w_en`, `data_in` and `r_en` directly.

## Interface
- NUM_REQ, 4, number of spike sources (≥2)
- DATA_WIDTH, 8, spike packet width; must match the FIFO
- DEPTH, 8, FIFO depth; must match the FIFO (power of two)
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset; shared with the FIFO
- req_valid  in  NUM_REQ  source i has a packet
- req_data  in  NUM_REQ*DATA_WIDTH  packet of source i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  one-hot grant; packet i is accepted when req_valid[i] & req_ready[i]
- fifo_w_en  out  1  to FIFO w_en
- fifo_data_in  out  DATA_WIDTH  to FIFO data_in
- fifo_full  in  1  from FIFO full
- fifo_r_en  out  1  to FIFO r_en
- fifo_empty  in  1  from FIFO empty
- fifo_valid  in  1  from FIFO valid (read data on data_out)
- tick  in  1  single-cycle tick strobe
- busy  out  1  drain in progress (state ≠ IDLE)
- tick_done  out  1  one-cycle pulse at the end of the drain
- drained_cnt  out  $clog2(DEPTH)+1  number of fifo_valid beats in the last drain
- tick_overrun  out  1  sticky error flag

## Operation
- **Write arbitration (combinational grant, registered pointer)**
  - Grant is the first i with req_valid[i] = 1, searching from rr_ptr upward modulo NUM_REQ.
  - No grant while fifo_full = 1.
  - req_ready = grant; fifo_w_en = |grant; fifo_data_in = the granted source's data, else 0.
  - On accept, rr_ptr ← granted index + 1, modulo NUM_REQ. Otherwise rr_ptr holds.
  - Writes are allowed in every state. Packets written during a drain belong to the next tick.
- **Occupancy counter `occ`** ($clog2(DEPTH)+1 bits)
  - +1 on accept, −1 on fifo_r_en, unchanged when both occur in the same cycle.
  - Must never exceed DEPTH or underflow.
- **FSM states**
  - IDLE
    - tick & occ>0: remaining ← occ, go to DRAIN.
    - tick & occ==0: go to DONE.
  - DRAIN
    - fifo_r_en = 1 every cycle.
    - remaining decrements each cycle.
    - When remaining==1, go to FLUSH.
  - FLUSH: one cycle, fifo_r_en = 0, captures the final fifo_valid beat.
  - DONE: tick_done = 1 for one cycle, drained_cnt ← beat counter, go to IDLE.
- **Beat counter**
  - Cleared on leaving IDLE.
  - Increments on each fifo_valid seen in DRAIN or FLUSH.
- **Error handling**
  - fifo_r_en is never asserted while fifo_empty = 1. If remaining>0 and fifo_empty = 1, set tick_overrun and go to FLUSH.
  - A tick arriving in any state other than IDLE is ignored and sets tick_overrun.
  - tick_overrun clears only on rst.

## Timing
- **Reset values (outputs at the first edge with rst = 1)**
  - state = IDLE, rr_ptr = 0, occ = 0, remaining = 0.
  - fifo_r_en = 0, busy = 0, tick_done = 0, drained_cnt = 0, tick_overrun = 0.
  - fifo_w_en and req_ready are 0 while rst is high.
  - Reset mid-drain aborts immediately; no tick_done is produced.
- **Write path**
  - Zero-cycle grant; the accept takes effect at the same edge.
  - One packet per cycle.
  - occ reflects the write one cycle later.
- **Drain with N = occ > 0 and tick sampled at edge T**
  - fifo_r_en high for cycles T+1 … T+N.
  - fifo_valid at T+2 … T+N+1.
  - FLUSH at T+N+1.
  - tick_done at T+N+2.
  - busy high T+1 … T+N+2.
- **Drain with N = 0:** tick_done at T+1, with busy high for that cycle only.
- The snapshot is taken at edge T. A write accepted in the same cycle as tick is not included.
- Minimum tick spacing is N+3 cycles; anything closer is an overrun.

## Test plan
- **Reset:** hold rst for 2 cycles mid-drain → all outputs 0, state IDLE, no tick_done; a following tick with an empty FIFO gives tick_done exactly 1 cycle later.
- **Round-robin fairness:** all 4 sources hold valid, packets 0xA0+i, FIFO not full → accept order 0,1,2,3,0, one per cycle, req_ready one-hot.
- **Full back-pressure:** write 8 packets (DEPTH = 8) → fifo_full = 1, req_ready = 0; one read then frees exactly one grant the next cycle.
- **Drain of 3:** occ = 3, tick at T → r_en T+1..T+3, valid T+2..T+4, tick_done at T+5, drained_cnt = 3.
- **Concurrent write during drain:** source 1 writes 0x55 while a drain of 2 runs → drained_cnt = 2, occ = 1 afterwards; the next tick drains 0x55.
- **Overrun:** a second tick 1 cycle after the first, with occ = 4 → tick ignored, tick_overrun = 1 and sticky, drain completes with drained_cnt = 4.

Source files
------------

// File: rtl/spike_fifo_sched.sv
// Round-robin write arbiter and per-tick drain scheduler for the axon-decoder spike FIFO.
// Merges NUM_REQ sources into the FIFO write port and drains the tick snapshot on each tick.
module spike_fifo_sched #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            fifo_w_en,
  output logic [DATA_WIDTH-1:0]           fifo_data_in,
  input  logic                            fifo_full,
  output logic                            fifo_r_en,
  input  logic                            fifo_empty,
  input  logic                            fifo_valid,
  input  logic                            tick,
  output logic                            busy,
  output logic                            tick_done,
  output logic [$clog2(DEPTH):0]          drained_cnt,
  output logic                            tick_overrun
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

  state_t            state, state_n;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     gidx;
  logic [PW:0]       cand;
  logic              found;
  logic [NUM_REQ-1:0] grant;
  logic              accept;
  logic [CW-1:0]     occ;
  logic [CW-1:0]     remaining;
  logic [CW-1:0]     beat;

  // Round-robin search from rr_ptr; occ guard keeps the counter bounded even if full lags.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_REQ)) begin
        cand = cand - (PW+1)'(NUM_REQ);
      end else begin
        cand = cand;
      end
      if (!found && req_valid[cand[PW-1:0]]) begin
        found = 1'b1;
        gidx  = cand[PW-1:0];
      end else begin
        found = found;
      end
    end
    if (found && !fifo_full && !rst && (occ < CW'(DEPTH))) begin
      grant[gidx] = 1'b1;
    end else begin
      grant = '0;
    end
  end

  assign accept       = |grant;
  assign req_ready    = grant;
  assign fifo_w_en    = accept;
  assign fifo_data_in = accept ? req_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH] : '0;

  // Reads are gated by fifo_empty so an unexpected empty FIFO is never popped.
  assign fifo_r_en = (state == DRAIN) && !fifo_empty && (remaining != '0);
  assign busy      = (state != IDLE);
  assign tick_done = (state == DONE);

  // Next-state logic for the drain sequence.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (tick) begin
          state_n = (occ != '0) ? DRAIN : DONE;
        end else begin
          state_n = IDLE;
        end
      end
      DRAIN: begin
        if (fifo_empty || (remaining <= CW'(1))) begin
          state_n = FLUSH;
        end else begin
          state_n = DRAIN;
        end
      end
      FLUSH:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, pointer, occupancy, beat counting and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      occ          <= '0;
      remaining    <= '0;
      beat         <= '0;
      drained_cnt  <= '0;
      tick_overrun <= 1'b0;
    end else begin
      state <= state_n;

      if (accept) begin
        rr_ptr <= (gidx == PW'(NUM_REQ-1)) ? '0 : gidx + PW'(1);
      end

      if (accept && !fifo_r_en && (occ < CW'(DEPTH))) begin
        occ <= occ + CW'(1);
      end else if (!accept && fifo_r_en && (occ != '0)) begin
        occ <= occ - CW'(1);
      end

      if ((state == IDLE) && tick) begin
        remaining <= occ;
      end else if (state == DRAIN) begin
        remaining <= fifo_r_en ? remaining - CW'(1) : '0;
      end

      if ((state == IDLE) && tick) begin
        beat <= '0;
      end else if (((state == DRAIN) || (state == FLUSH)) && fifo_valid) begin
        beat <= beat + CW'(1);
      end

      if (state == DONE) begin
        drained_cnt <= beat;
      end

      if ((tick && (state != IDLE)) ||
          ((state == DRAIN) && (remaining != '0) && fifo_empty)) begin
        tick_overrun <= 1'b1;
      end
    end
  end

endmodule
